// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_event_decoder
// Brief    : Turns a debounced key into short/long/repeat/double-click pulses.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int DCLICK_TICKS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_level,
  input  logic key_press,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic double_click,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_PRESSED        = 3'd1,
    S_LONG_HELD      = 3'd2,
    S_WAIT_SECOND    = 3'd3,
    S_SECOND_PRESSED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_reach_long;
  logic             w_reach_repeat;
  logic             w_reach_dclick;
  logic             w_short;
  logic             w_long;
  logic             w_repeat;
  logic             w_dclick;

  // Saturating increment: SECOND_PRESSED has no timeout, so the count must not wrap.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (tick && (r_cnt != c_cnt_max)) begin
      w_cnt_inc = r_cnt + CNT_W'(1);
    end
  end

  assign w_reach_long   = tick && (r_cnt == c_long_last);
  assign w_reach_repeat = tick && (r_cnt == c_repeat_last);
  assign w_reach_dclick = tick && (r_cnt == c_dclick_last);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = w_cnt_inc;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    w_dclick     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (key_press) begin
          w_next_state = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (!key_level) begin
          w_next_state = S_WAIT_SECOND;
          w_next_cnt   = '0;
        end else if (w_reach_long) begin
          w_long       = 1'b1;
          w_next_state = S_LONG_HELD;
          w_next_cnt   = '0;
        end
      end
      S_LONG_HELD: begin
        if (!key_level) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end else if (w_reach_repeat) begin
          w_repeat   = 1'b1;
          w_next_cnt = '0;
        end
      end
      S_WAIT_SECOND: begin
        if (key_press) begin
          w_next_state = S_SECOND_PRESSED;
          w_next_cnt   = '0;
        end else if (w_reach_dclick) begin
          w_short      = 1'b1;
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end
      end
      S_SECOND_PRESSED: begin
        if (!key_level) begin
          w_dclick     = 1'b1;
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_evt   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      short_press  <= w_short;
      long_press   <= w_long;
      repeat_evt   <= w_repeat;
      double_click <= w_dclick;
      busy         <= (w_next_state != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_decoder
// Brief    : Vector table, directed corner cases and randomized run vs. model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

  localparam int LONG   = 8;
  localparam int REPEAT = 3;
  localparam int DCLICK = 4;

  logic clk = 1'b0;
  logic rst, tick, key_level, key_press;
  logic short_press, long_press, repeat_evt, double_click, busy;

  int checks = 0;
  int passes = 0;

  key_event_decoder #(
    .CNT_W(4), .LONG_TICKS(LONG), .REPEAT_TICKS(REPEAT), .DCLICK_TICKS(DCLICK)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_level(key_level), .key_press(key_press),
    .short_press(short_press), .long_press(long_press), .repeat_evt(repeat_evt),
    .double_click(double_click), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: phase plus ticks elapsed since entering it; repeats use modulo.
  int         m_phase = 0;  // 0 idle, 1 held, 2 long-held, 3 gap, 4 second hold
  int         m_ticks = 0;
  logic [4:0] m_out   = '0; // {short, long, repeat, dclick, busy}

  function automatic void m_enter(int ph);
    m_phase = ph;
    m_ticks = 0;
  endfunction

  function automatic void model_step(logic r, logic t, logic l, logic p);
    m_out = '0;
    if (r) m_enter(0);
    else begin
      case (m_phase)
        0: if (p) m_enter(1);
        1: if (!l) m_enter(3);
           else if (t && m_ticks + 1 == LONG) begin m_out[3] = 1'b1; m_enter(2); end
           else if (t) m_ticks++;
        2: if (!l) m_enter(0);
           else if (t) begin
             m_ticks++;
             if (m_ticks % REPEAT == 0) m_out[2] = 1'b1;
           end
        3: if (p) m_enter(4);
           else if (t && m_ticks + 1 == DCLICK) begin m_out[4] = 1'b1; m_enter(0); end
           else if (t) m_ticks++;
        4: if (!l) begin m_out[1] = 1'b1; m_enter(0); end
        default: m_enter(0);
      endcase
    end
    m_out[0] = (m_phase != 0);
  endfunction

  task automatic clk_cycle(input logic t, input logic l, input logic p, input logic r);
    tick = t; key_level = l; key_press = p; rst = r;
    model_step(r, t, l, p);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {short_press, long_press, repeat_evt, double_click, busy};
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got {short,long,rep,dclk,busy}=%b want %b", name, act, exp);
  endtask

  // One tick period: tick edge with the given inputs, then three quiet clocks.
  task automatic step(input logic r, input logic l, input logic p, input logic [4:0] exp,
                      input string name);
    clk_cycle(1'b1, l, p, r);
    check(name, exp);
    for (int k = 0; k < 3; k++) begin
      clk_cycle(1'b0, l, 1'b0, 1'b0);
      check({name, "_q"}, exp & 5'b00001);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       lvl;
    logic       prs;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic l, logic p, logic [4:0] e, int n = 1);
    vec_t v;
    v.rst = r; v.lvl = l; v.prs = p; v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  logic r_lvl, r_prs, r_rst, r_tick;

  initial begin
    // short press: held 3 ticks, short_press 4 ticks after release
    add(1, 0, 0, 5'b00000);
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001, 2);
    add(0, 0, 0, 5'b00001, 4);
    add(0, 0, 0, 5'b10000);
    add(0, 0, 0, 5'b00000);
    // long press with repeats at ticks 11 and 14, silent release
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001, 7);
    add(0, 1, 0, 5'b01001);
    add(0, 1, 0, 5'b00001, 2);
    add(0, 1, 0, 5'b00101);
    add(0, 1, 0, 5'b00001, 2);
    add(0, 1, 0, 5'b00101);
    add(0, 1, 0, 5'b00001);
    add(0, 0, 0, 5'b00000, 2);
    // double click, no short_press afterwards
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001);
    add(0, 0, 0, 5'b00001, 2);
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001);
    add(0, 0, 0, 5'b00010);
    add(0, 0, 0, 5'b00000, 5);
    // release on the LONG-th tick, re-press on the DCLICK-th tick
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001, 7);
    add(0, 0, 0, 5'b00001);
    add(0, 0, 0, 5'b00001, 3);
    add(0, 1, 1, 5'b00001);
    add(0, 1, 0, 5'b00001);
    add(0, 0, 0, 5'b00010);
    add(0, 0, 0, 5'b00000, 5);

    clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset", 5'b00000);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].lvl, vecs[i].prs, vecs[i].exp, $sformatf("vec%0d", i));

    // release on a non-tick clock is seen immediately
    step(0, 1, 1, 5'b00001, "nt_press");
    step(0, 1, 0, 5'b00001, "nt_hold");
    clk_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("nt_tick", 5'b00001);
    for (int k = 0; k < 3; k++) begin
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("nt_rel", 5'b00001);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 5'b00001, "nt_wait");
    step(0, 0, 0, 5'b10000, "nt_short");

    // reset during WAIT_SECOND drops the pending short_press
    step(0, 1, 1, 5'b00001, "rw_press");
    step(0, 0, 0, 5'b00001, "rw_rel");
    step(0, 0, 0, 5'b00001, "rw_wait");
    clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rw_rst", 5'b00000);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 5'b00000, "rw_after");

    // key_press pulses while long-held, with tick stalled for 50 clocks
    step(0, 1, 1, 5'b00001, "lh_press");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 5'b00001, "lh_hold");
    step(0, 1, 0, 5'b01001, "lh_long");
    for (int k = 0; k < 50; k++) begin
      clk_cycle(1'b0, 1'b1, (k % 5) == 0, 1'b0);
      check("lh_stall", 5'b00001);
    end
    step(0, 1, 0, 5'b00001, "lh_t1");
    step(0, 1, 0, 5'b00001, "lh_t2");
    step(0, 1, 0, 5'b00101, "lh_rep");
    step(0, 0, 0, 5'b00000, "lh_rel");

    // randomized run against the reference model
    r_lvl = 1'b0;
    clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rand_rst", m_out);
    for (int i = 0; i < 4000; i++) begin
      r_tick = (i % 4) == 0;
      r_prs  = 1'b0;
      r_rst  = ($urandom % 600) == 0;
      if (!r_lvl) begin
        if (r_tick && ($urandom % 3) == 0) begin
          r_lvl = 1'b1;
          r_prs = 1'b1;
        end
      end else if (($urandom % 20) == 0) begin
        r_lvl = 1'b0;
      end else if (r_tick && ($urandom % 12) == 0) begin
        r_prs = 1'b1;
      end
      clk_cycle(r_tick, r_lvl, r_prs, r_rst);
      check($sformatf("rand%0d", i), m_out);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
